// File: rtl/term_pc_defs.sv
// term_pc_defs: shared FSM state encodings for the bit-serial adder
package term_pc_defs;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/fulladder.sv
// fulladder: 1-bit combinational full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic c0,
  output logic c1,
  output logic f
);
  assign f  = a ^ b ^ c0;
  assign c1 = (a & b) | (c0 & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial adder sequencing one fulladder cell
module serial_adder
  import term_pc_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nx;
  logic [CNT_W-1:0] cnt;
  logic carry, c1, f, last, c_msb;
  fulladder u_fa (
    .a (a_sh[0]),
    .b (b_sh[0]),
    .c0(carry),
    .c1(c1),
    .f (f)
  );
  assign last   = cnt == CNT_W'(WIDTH - 1);
  assign c_msb  = carry;
  assign res_nx = (res_sh >> 1) | (WIDTH'(f) << (WIDTH - 1));
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  // Next state; DONE and the illegal encoding both fall back to IDLE
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == IDLE)  ? (start ? SHIFT : IDLE) :
               (state == SHIFT) ? (last ? DONE : SHIFT) : IDLE;
  end
  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end
  // Operand load, one bit step per SHIFT cycle, result capture on the last step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nx;
      carry  <= c1;
      cnt    <= cnt + CNT_W'(1);
      if (last) begin
        sum  <= res_nx;
        cout <= c1;
        ovf  <= c_msb ^ c1;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder against an arithmetic model
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, cin = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] sum1;
  int cmp = 0, errs = 0;
  logic [7:0] prev_sum = '0;
  logic       prev_cout = 1'b0, prev_ovf = 1'b0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer addition; signed overflow when both operands share a sign the sum lacks
  function automatic logic [9:0] model(input int w, input int x, input int y, input int ci);
    int s = x + y + ci;
    int m = (1 << w) - 1;
    logic sx = 1'((x >> (w - 1)) & 1);
    logic sy = 1'((y >> (w - 1)) & 1);
    logic ss = 1'((s >> (w - 1)) & 1);
    return {(sx == sy) && (ss != sx), 1'((s >> w) & 1), 8'(s & m)};
  endfunction

  task automatic op(input logic [7:0] x, input logic [7:0] y, input logic ci, input int poke);
    logic [9:0] r = model(8, int'(x), int'(y), int'(ci));
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      chk("busy", 32'(busy), 32'd1);
      chk("done_lo", 32'(done), 32'd0);
      chk("sum_hold", 32'({prev_ovf, prev_cout, prev_sum}), 32'({ovf, cout, sum}));
      if (i == poke) begin
        start = 1'b1; a = 8'h01; b = 8'h01;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done", 32'(done), 32'd1);
    chk("busy_lo", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(r[7:0]));
    chk("cout", 32'(cout), 32'(r[8]));
    chk("ovf", 32'(ovf), 32'(r[9]));
    @(posedge clk); #1;
    chk("done_once", 32'(done), 32'd0);
    chk("idle", 32'(busy), 32'd0);
    {prev_ovf, prev_cout, prev_sum} = r;
  endtask

  initial begin
    logic [9:0] r;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res", 32'({ovf, cout, sum}), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    op(8'h5A, 8'h33, 1'b0, -1);
    chk("t1_sum", 32'(sum), 32'h8D);
    chk("t1_ovf", 32'(ovf), 32'd1);
    op(8'hFF, 8'h01, 1'b0, -1);
    chk("t2_sum", 32'({cout, sum}), 32'h100);
    op(8'hFF, 8'hFF, 1'b1, -1);
    chk("t3_sum", 32'({ovf, cout, sum}), 32'h1FF);
    op(8'h80, 8'h80, 1'b0, -1);
    chk("t4_sum", 32'({ovf, cout, sum}), 32'h300);
    op(8'h12, 8'h34, 1'b1, 3);
    chk("t5_sum", 32'(sum), 32'h47);
    for (int k = 0; k < 20; k++)
      op(8'($urandom), 8'($urandom), 1'($urandom), (k % 4 == 0) ? int'($urandom_range(0, 7)) : -1);
    // asynchronous reset between edges during SHIFT
    @(negedge clk);
    a = 8'hC3; b = 8'h7E; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_res", 32'({ovf, cout, sum}), 32'd0);
    {prev_ovf, prev_cout, prev_sum} = '0;
    @(negedge clk); rst_n = 1'b1;
    op(8'h10, 8'h20, 1'b0, -1);
    chk("arst_new", 32'(sum), 32'h30);
    // WIDTH=1 instance: directed case then random
    for (int k = 0; k < 6; k++) begin
      logic x = (k == 0) ? 1'b1 : 1'($urandom);
      logic y = (k == 0) ? 1'b1 : 1'($urandom);
      logic c = (k == 0) ? 1'b1 : 1'($urandom);
      r = model(1, int'(x), int'(y), int'(c));
      @(negedge clk);
      a1 = x; b1 = y; cin1 = c; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      chk("w1_busy", 32'(busy1), 32'd1);
      @(posedge clk); #1;
      chk("w1_done", 32'(done1), 32'd1);
      chk("w1_res", 32'({ovf1, cout1, sum1}), 32'({r[9], r[8], r[0]}));
      chk("w1_ovf_rule", 32'(ovf1), 32'(c ^ r[8]));
      @(posedge clk); #1;
      chk("w1_done_once", 32'(done1), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder that drives the existing 1-bit `fulladder` stage.
- Adds two WIDTH-bit operands plus a carry-in, LSB first, one bit per clock. A flip-flop holds the carry between bits.
- Result is captured into output registers and signalled with a one-cycle `done` pulse.
- Consumes what `fulladder` produces (f, c1) and feeds c1 back as c0. It is the sequencing stage wrapped around the adder cell.

Parameters:
- WIDTH, 8, operand/result width in bits; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  operand A, captured on the accepting edge.
- b  in  WIDTH  operand B, captured on the accepting edge.
- cin  in  1  carry-in, captured on the accepting edge.
- busy  out  1  high while in SHIFT.
- done  out  1  one-cycle pulse; sum/cout/ovf valid.
- sum  out  WIDTH  registered result.
- cout  out  1  registered carry out of MSB.
- ovf  out  1  registered signed overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Interface: one clock (clk). Reset rst_n is asynchronous and active-low. All flops clear immediately on rst_n=0, independent of clk.
- Reset values:
  - State IDLE; busy=0, done=0.
  - sum=0, cout=0, ovf=0.
  - Working shift registers, carry flop and bit counter all 0.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: if start=1 at edge E0, load a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, then go to SHIFT. Otherwise stay.
  - SHIFT: each edge performs one bit step:
    - fulladder inputs are a_sh[0], b_sh[0], carry.
    - res_sh <= {f, res_sh[WIDTH-1:1]}.
    - a_sh and b_sh shift right by 1.
    - carry <= c1; cnt <= cnt+1.
    - On the step where cnt==WIDTH-1, the carry value entering that step is saved as c_msb.
    - On that final step (edge E0+WIDTH):
      - sum <= {f, res_sh[WIDTH-1:1]}
      - cout <= c1
      - ovf <= c_msb ^ c1
      - next state DONE.
  - DONE: done=1 for exactly this cycle, then unconditionally go to IDLE.
- Latency:
  - The accepting edge is E0; busy=1 during cycles E0+1 .. E0+WIDTH.
  - done=1 in the cycle after edge E0+WIDTH.
  - Earliest next accept is edge E0+WIDTH+2.
- Outputs: busy = (state==SHIFT) and done = (state==DONE), both decoded from registered state (glitch-free).
- Result hold: sum/cout/ovf hold the previous result throughout a new operation. They change only on a final SHIFT step.
- start handling:
  - start during SHIFT or DONE is ignored, not queued.
  - start held high continuously yields back-to-back operations, one per WIDTH+2 cycles.
  - Operand changes after the accepting edge have no effect.
- Reset mid-operation: abort; everything returns to reset values. The previous result is lost (sum=0).
- WIDTH=1: single SHIFT step. c_msb=cin, so ovf = cin ^ cout.
- Counter width: CNT_W = max(1, clog2(WIDTH)). No wrap is reachable because the counter is reloaded on every accept.

Decomposition:
- Shared package/header `term_pc_defs`: FSM state encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2; encoding 2'd3 is illegal and recovers to IDLE.
- Sub-module: reuse the existing `fulladder` (ports a, b, c0, c1, f), instantiated exactly once, purely combinational.
- No other sub-modules.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0, start pulse:
  - busy high for 8 cycles, then done pulses once.
  - sum=0x8D, cout=0, ovf=1.
- WIDTH=8, a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1, ovf=0.
- WIDTH=8, a=0x80, b=0x80, cin=0 → sum=0x00, cout=1, ovf=1. While this runs, sum still shows 0xFF from the prior operation until the final step.
- start pulsed at SHIFT cycle 3 with a=0x01, b=0x01:
  - ignored; the original result completes.
  - done pulses exactly once, at E0+WIDTH+1.
- rst_n dropped asynchronously mid-SHIFT (between edges, cycle 4):
  - busy/done/sum/cout/ovf go to 0 immediately.
  - after release, a new start a=0x10, b=0x20 gives sum=0x30.
- WIDTH=1, a=1, b=1, cin=1 → sum=1, cout=1, ovf=0; done at the second edge after accept.
